// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared sizing helpers and default parameters for the first-word fall-through FIFO.
package dpram_fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_ADDR_WIDTH    = 4;
  localparam int unsigned DEF_AFULL_THRESH  = 12;
  localparam int unsigned DEF_AEMPTY_THRESH = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Pointers and count carry one extra bit so full and empty stay distinct.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  function automatic bit thresh_ok(input int unsigned depth,
                                   input int unsigned afull,
                                   input int unsigned aempty);
    return (afull > 0) && (afull <= depth) && (aempty < depth);
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module fifo_mem
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array is never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller: pointers, head prefetch, occupancy count and registered flags.
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = cnt_width(ADDR_WIDTH);

  if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("dpram_fifo_ctrl: illegal almost_full/almost_empty thresholds");
  end

  logic [CW-1:0]         r_wptr;
  logic [CW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_rd_valid;
  logic                  r_wr_ready;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;

  logic [CW-1:0]         w_ram_occ;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_re;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_rd_valid_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_ram_occ = r_wptr - r_rptr;

  // Flush wins over both handshakes in its cycle; a full FIFO never passes through.
  assign w_push = wr_valid & r_wr_ready & ~flush;
  assign w_pop  = r_rd_valid & rd_ready & ~flush;
  assign w_re   = (w_ram_occ != '0) & (~r_rd_valid | w_pop) & ~flush;

  always_comb begin
    w_count_nxt    = r_count;
    w_rd_valid_nxt = r_rd_valid;
    if (flush) begin
      w_count_nxt    = '0;
      w_rd_valid_nxt = 1'b0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      if (w_re) begin
        w_rd_valid_nxt = 1'b1;
      end else if (w_pop) begin
        w_rd_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + CW'(1);
      end
      if (w_re) begin
        r_rptr <= r_rptr + CW'(1);
      end
      r_count    <= w_count_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  // Flags are registered from the next count so none sees wr_valid/rd_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ready <= 1'b1;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
    end else begin
      r_wr_ready <= (w_count_nxt != CW'(DEPTH));
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_afull    <= (w_count_nxt >= CW'(AFULL_THRESH));
      r_aempty   <= (w_count_nxt <= CW'(AEMPTY_THRESH));
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_push),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (wr_data),
    .i_re    (w_re),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  // A read can only target a written slot, and writes stop at full, so addresses never collide.
  a_no_collide: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_re && (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0])));

  assign wr_ready     = r_wr_ready;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = w_rdata;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

endmodule
